m_stopwatch_cnt: RTL and testbench

- Stopwatch time-keeping stage that sits directly downstream of the 10 ms tick generator.
- Detects rising edges of the clk10ms signal in the clk domain and counts elapsed time in BCD as MM:SS.cc (minutes, seconds, centiseconds).
- Contains the start/stop/clear control FSM.
- Its BCD digit outputs feed the 7-segment display driver.

---
 rtl/m_stopwatch_cnt_pkg.sv | 20 ++
 rtl/m_stopwatch_cnt_bcd_digit.sv | 46 ++++
 rtl/m_stopwatch_cnt.sv | 109 ++++++++++
 tb/tb_m_stopwatch_cnt.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/m_stopwatch_cnt_pkg.sv
// Shared types and constants for the stopwatch time-keeping stage.
//   t_sw_state : control FSM state encoding (IDLE, RUN, PAUSE)
//   t_bcd      : one BCD digit
//   C_CS_MAX   : highest value of a decimal digit (centiseconds, seconds ones, minutes)
//   C_S1_MAX   : highest value of the seconds tens digit
package pkg_stopwatch;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } t_sw_state;

  localparam int unsigned C_BCD_W  = 4;
  localparam int unsigned C_CS_MAX = 9;
  localparam int unsigned C_S1_MAX = 5;

  typedef logic [C_BCD_W-1:0] t_bcd;

endpackage

// File: rtl/m_stopwatch_cnt_bcd_digit.sv
// One BCD counter digit that rolls over from P_MAX to 0.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : advance the digit by one this cycle
//   clr      : force the digit to 0 (has priority over inc)
//   q        : registered digit value
//   carry    : combinational, high when inc rolls this digit over
module m_bcd_digit
  import pkg_stopwatch::*;
#(
  parameter int unsigned P_MAX = C_CS_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [C_BCD_W-1:0] q,
  output logic               carry
);

  t_bcd q_q;
  t_bcd q_d;
  logic at_max;

  assign at_max = (q_q == t_bcd'(P_MAX));
  assign carry  = inc & at_max;
  assign q      = q_q;

  // Next digit value: clear wins, otherwise increment with rollover.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = at_max ? '0 : t_bcd'(q_q + t_bcd'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/m_stopwatch_cnt.sv
// Stopwatch time-keeping stage: detects clk10ms rising edges and counts
// elapsed time as BCD MM:SS.cc under a start/stop/clear control FSM.
//   clk, rst          : system clock, asynchronous active-high reset
//   clk10ms           : 10 ms clock, synchronous to clk, rising edges used
//   start_stop, clear : single-cycle debounced control pulses
//   cs0..m1           : registered BCD digits for the display driver
//   running           : registered, high while in RUN
//   ovf               : registered one-cycle pulse on wrap to 00:00.00
module m_stopwatch_cnt
  import pkg_stopwatch::*;
#(
  parameter int unsigned P_MAX_MIN = 59
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk10ms,
  input  logic               start_stop,
  input  logic               clear,
  output logic [C_BCD_W-1:0] cs0,
  output logic [C_BCD_W-1:0] cs1,
  output logic [C_BCD_W-1:0] s0,
  output logic [C_BCD_W-1:0] s1,
  output logic [C_BCD_W-1:0] m0,
  output logic [C_BCD_W-1:0] m1,
  output logic               running,
  output logic               ovf
);

  localparam t_bcd C_M1_MAX = t_bcd'(P_MAX_MIN / 10);
  localparam t_bcd C_M0_MAX = t_bcd'(P_MAX_MIN % 10);

  t_sw_state state_q;
  t_sw_state state_d;
  logic      clk10ms_q;
  logic      running_q;
  logic      ovf_q;

  logic tick;
  logic cnt_inc;
  logic cnt_clr;
  logic wrap;
  logic c_cs0, c_cs1, c_s0, c_s1, c_m0, c_m1;

  // Edge detect; the register resets high so a high clk10ms at reset release is not a tick.
  assign tick    = clk10ms & ~clk10ms_q;
  assign cnt_inc = tick & (state_q == RUN);

  // Wrap at P_MAX_MIN:59.99; an m1 rollover (only reachable at 99 minutes) wraps too.
  assign wrap = (cnt_inc & (m1 == C_M1_MAX) & (m0 == C_M0_MAX) &
                 (s1 == t_bcd'(C_S1_MAX)) & (s0 == t_bcd'(C_CS_MAX)) &
                 (cs1 == t_bcd'(C_CS_MAX)) & (cs0 == t_bcd'(C_CS_MAX))) | c_m1;

  assign cnt_clr = wrap | ((state_q == PAUSE) & clear);

  // Control FSM next state; clear beats start_stop in PAUSE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_stop) state_d = RUN;
      RUN:     if (start_stop) state_d = PAUSE;
      PAUSE: begin
        if (clear) begin
          state_d = IDLE;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk10ms_q <= 1'b1;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk10ms_q <= clk10ms;
      running_q <= (state_d == RUN);
      ovf_q     <= wrap;
    end
  end

  assign running = running_q;
  assign ovf     = ovf_q;

  // Ripple-carry digit chain, least significant first.
  m_bcd_digit #(.P_MAX(C_CS_MAX)) u_cs0 (
    .clk(clk), .rst(rst), .inc(cnt_inc), .clr(cnt_clr), .q(cs0), .carry(c_cs0)
  );
  m_bcd_digit #(.P_MAX(C_CS_MAX)) u_cs1 (
    .clk(clk), .rst(rst), .inc(c_cs0), .clr(cnt_clr), .q(cs1), .carry(c_cs1)
  );
  m_bcd_digit #(.P_MAX(C_CS_MAX)) u_s0 (
    .clk(clk), .rst(rst), .inc(c_cs1), .clr(cnt_clr), .q(s0), .carry(c_s0)
  );
  m_bcd_digit #(.P_MAX(C_S1_MAX)) u_s1 (
    .clk(clk), .rst(rst), .inc(c_s0), .clr(cnt_clr), .q(s1), .carry(c_s1)
  );
  m_bcd_digit #(.P_MAX(C_CS_MAX)) u_m0 (
    .clk(clk), .rst(rst), .inc(c_s1), .clr(cnt_clr), .q(m0), .carry(c_m0)
  );
  m_bcd_digit #(.P_MAX(C_CS_MAX)) u_m1 (
    .clk(clk), .rst(rst), .inc(c_m0), .clr(cnt_clr), .q(m1), .carry(c_m1)
  );

endmodule

// File: tb/tb_m_stopwatch_cnt.sv
// Directed self-checking bench for m_stopwatch_cnt (P_MAX_MIN = 1).
module tb_m_stopwatch_cnt;

  logic       clk;
  logic       rst;
  logic       clk10ms;
  logic       start_stop;
  logic       clear;
  logic [3:0] cs0, cs1, s0, s1, m0, m1;
  logic       running;
  logic       ovf;

  int total;
  int bad;

  m_stopwatch_cnt #(.P_MAX_MIN(1)) dut (
    .clk(clk), .rst(rst), .clk10ms(clk10ms), .start_stop(start_stop), .clear(clear),
    .cs0(cs0), .cs1(cs1), .s0(s0), .s1(s1), .m0(m0), .m1(m1),
    .running(running), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] disp();
    return {m1, m0, s1, s0, cs1, cs0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clk10ms rising edge; returns on the falling clk edge after it was counted.
  task automatic tick();
    @(negedge clk);
    clk10ms = 1'b1;
    @(negedge clk);
    clk10ms = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_ss();
    @(negedge clk);
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; clk10ms = 1'b1; start_stop = 1'b0; clear = 1'b0;

    // Reset with clk10ms held high: no false tick after release.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_disp", 32'(disp()), 32'h000000);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    pulse_ss();
    chk("start_no_false_tick", 32'(disp()), 32'h000000);
    chk("start_running", 32'(running), 32'h1);
    @(negedge clk);
    clk10ms = 1'b0;

    // 123 ticks, then one-clk latency of the 124th.
    ticks(123);
    chk("cnt_123", 32'(disp()), 32'h000123);
    @(negedge clk);
    clk10ms = 1'b1;
    #1;
    chk("lat_before_edge", 32'(disp()), 32'h000123);
    @(negedge clk);
    clk10ms = 1'b0;
    chk("lat_after_edge", 32'(disp()), 32'h000124);

    // Pause, clear back to zero.
    pulse_ss();
    chk("pause_running", 32'(running), 32'h0);
    tick();
    chk("pause_frozen", 32'(disp()), 32'h000124);
    pulse_clr();
    chk("clear_zero", 32'(disp()), 32'h000000);

    // Stop on the same cycle as a tick at 00:00.49: that tick counts.
    pulse_ss();
    ticks(49);
    chk("cnt_49", 32'(disp()), 32'h000049);
    @(negedge clk);
    clk10ms = 1'b1; start_stop = 1'b1;
    @(negedge clk);
    clk10ms = 1'b0; start_stop = 1'b0;
    chk("stop_tick_counted", 32'(disp()), 32'h000050);
    chk("stop_running", 32'(running), 32'h0);
    ticks(10);
    chk("paused_10_ticks", 32'(disp()), 32'h000050);
    pulse_clr();
    chk("clear2_zero", 32'(disp()), 32'h000000);
    chk("clear2_running", 32'(running), 32'h0);
    pulse_clr();
    chk("idle_clear_noop", 32'(disp()), 32'h000000);
    tick();
    chk("idle_tick_discarded", 32'(disp()), 32'h000000);

    // Start on the same cycle as a tick: that tick is not counted.
    @(negedge clk);
    clk10ms = 1'b1; start_stop = 1'b1;
    @(negedge clk);
    clk10ms = 1'b0; start_stop = 1'b0;
    chk("start_tick_dropped", 32'(disp()), 32'h000000);
    chk("start2_running", 32'(running), 32'h1);

    // Clear ignored in RUN.
    pulse_clr();
    chk("run_clear_running", 32'(running), 32'h1);
    ticks(5);
    chk("run_clear_ignored", 32'(disp()), 32'h000005);

    // PAUSE with clear and start_stop together: clear wins.
    pulse_ss();
    @(negedge clk);
    clear = 1'b1; start_stop = 1'b1;
    @(negedge clk);
    clear = 1'b0; start_stop = 1'b0;
    chk("both_zero", 32'(disp()), 32'h000000);
    chk("both_running", 32'(running), 32'h0);
    tick();
    chk("both_idle_tick", 32'(disp()), 32'h000000);

    // Preload to 01:59.99 and wrap.
    pulse_ss();
    ticks(11999);
    chk("preload_max", 32'(disp()), 32'h015999);
    chk("preload_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    clk10ms = 1'b1;
    @(negedge clk);
    chk("wrap_zero", 32'(disp()), 32'h000000);
    chk("wrap_ovf", 32'(ovf), 32'h1);
    chk("wrap_running", 32'(running), 32'h1);
    @(negedge clk);
    clk10ms = 1'b0;
    chk("wrap_ovf_one_cycle", 32'(ovf), 32'h0);
    tick();
    chk("after_wrap", 32'(disp()), 32'h000001);

    // Asynchronous reset mid-count at 00:37.15.
    ticks(3714);
    chk("cnt_3715", 32'(disp()), 32'h003715);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_disp", 32'(disp()), 32'h000000);
    chk("async_rst_running", 32'(running), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 32'(disp()), 32'h000000);
    chk("post_rst_running", 32'(running), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
